seg7_mux_capture: RTL and testbench



---
 rtl/seg7_mux_capture_pkg.sv | 30 +++
 rtl/seg7_settle_filter.sv | 42 ++++
 rtl/seg7_mux_capture.sv | 105 ++++++++++
 tb/tb_seg7_mux_capture.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_mux_capture_pkg.sv
// Shared helpers for the scanned 7-segment capture block.
// Optional build macro used by this block: SEG7_MUX_CAPTURE_DECAY_EN.
package seg7_mux_capture_pkg;

  // Helper functions operate on vectors zero-extended to this width.
  localparam int unsigned MAX_W = 32;

  // Counter widths for the default parameter set.
  localparam int unsigned DEF_SETTLE       = 4;
  localparam int unsigned DEF_TIMEOUT      = 1048576;
  localparam int unsigned DEF_SETTLE_CNT_W = $clog2(DEF_SETTLE + 1);
  localparam int unsigned DEF_AGE_CNT_W    = $clog2(DEF_TIMEOUT + 1);

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

  // Map an input bus to active-high.
  function automatic logic [MAX_W-1:0] normalize(input logic [MAX_W-1:0] v,
                                                 input logic inv);
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_settle_filter.sv
// Samples the scan bus and flags the one cycle a held sample becomes settled.
module seg7_settle_filter
  import seg7_mux_capture_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned SETTLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] sample,
  output logic         capture_c
);

  localparam int unsigned     CNT_W   = cnt_w(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] stable_cnt;
  logic             repeat_c;

  // The incoming sample matches the one already registered.
  assign repeat_c  = (din == sample);
  // Fires only on the SETTLE-1 -> SETTLE step, so a held pattern captures once.
  assign capture_c = repeat_c && (stable_cnt == CNT_ARM);

  // Sample register and saturating repeat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample     <= '0;
      stable_cnt <= '0;
    end else begin
      sample <= din;
      if (!repeat_c) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_mux_capture.sv
// Converts a multiplexed 7-segment scan into static per-digit registers
// with glitch filtering and refresh-age tracking.
// Build macro SEG7_MUX_CAPTURE_DECAY_EN: blank a digit when it goes stale.
module seg7_mux_capture
  import seg7_mux_capture_pkg::*;
#(
  parameter int unsigned W_DIGIT          = 8,
  parameter int unsigned W_SEG            = 8,
  parameter int unsigned SETTLE           = 4,
  parameter int unsigned TIMEOUT          = 1048576,
  parameter int unsigned DIGIT_ACTIVE_LOW = 0,
  parameter int unsigned SEG_ACTIVE_LOW   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_SEG-1:0]   hgfedcba,
  input  logic [W_DIGIT-1:0] digit,
  output logic [W_SEG-1:0]   hex [W_DIGIT],
  output logic [W_DIGIT-1:0] valid,
  output logic [W_DIGIT-1:0] update,
  output logic               multi_hot
);

  localparam int unsigned      W_ALL   = W_DIGIT + W_SEG;
  localparam int unsigned      AGE_W   = cnt_w(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  logic [W_DIGIT-1:0] dig_n;
  logic [W_SEG-1:0]   seg_n;
  logic [W_ALL-1:0]   sample;
  logic               capture_c;
  logic [W_DIGIT-1:0] s_dig;
  logic [W_SEG-1:0]   s_seg;
  logic               sel_onehot;

  logic [AGE_W-1:0]   age       [W_DIGIT];
  logic [AGE_W-1:0]   age_nxt   [W_DIGIT];
  logic [W_SEG-1:0]   hex_nxt   [W_DIGIT];
  logic [W_DIGIT-1:0] valid_nxt;
  logic [W_DIGIT-1:0] update_nxt;
  logic               multi_hot_nxt;

  // Polarity normalisation to active-high.
  assign dig_n = W_DIGIT'(normalize(MAX_W'(digit), DIGIT_ACTIVE_LOW != 0));
  assign seg_n = W_SEG'(normalize(MAX_W'(hgfedcba), SEG_ACTIVE_LOW != 0));

  seg7_settle_filter #(
    .W      (W_ALL),
    .SETTLE (SETTLE)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .din       ({dig_n, seg_n}),
    .sample    (sample),
    .capture_c (capture_c)
  );

  assign s_dig      = sample[W_ALL-1:W_SEG];
  assign s_seg      = sample[W_SEG-1:0];
  assign sel_onehot = is_onehot(MAX_W'(s_dig));

  // Next-state for digit registers, age counters and pulses.
  always_comb begin
    multi_hot_nxt = capture_c && (s_dig != '0) && !sel_onehot;
    valid_nxt     = '0;
    update_nxt    = '0;
    for (int i = 0; i < W_DIGIT; i++) begin
      age_nxt[i] = (age[i] == AGE_MAX) ? age[i] : age[i] + AGE_W'(1);
      hex_nxt[i] = hex[i];
      if (capture_c && sel_onehot && s_dig[i]) begin
        age_nxt[i]    = '0;
        hex_nxt[i]    = s_seg;
        update_nxt[i] = (s_seg != hex[i]);
      end
`ifdef SEG7_MUX_CAPTURE_DECAY_EN
      else if (age_nxt[i] == AGE_MAX) begin
        hex_nxt[i] = '0;
      end
`endif
      valid_nxt[i] = (age_nxt[i] != AGE_MAX);
    end
  end

  // Output and age registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W_DIGIT; i++) begin
        hex[i] <= '0;
        age[i] <= AGE_MAX;
      end
      valid     <= '0;
      update    <= '0;
      multi_hot <= 1'b0;
    end else begin
      for (int i = 0; i < W_DIGIT; i++) begin
        hex[i] <= hex_nxt[i];
        age[i] <= age_nxt[i];
      end
      valid     <= valid_nxt;
      update    <= update_nxt;
      multi_hot <= multi_hot_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_mux_capture.sv
// Scoreboard bench for seg7_mux_capture: two instances (active-high and
// active-low) share one logical scan stream; a run-length reference model
// predicts pulses and digit state.
`timescale 1ns/1ps
module tb_seg7_mux_capture;

  localparam int SET_A = 4;
  localparam int TMO_A = 64;
  localparam int SET_B = 2;
  localparam int TMO_B = 16;
`ifdef SEG7_MUX_CAPTURE_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dig = 8'h00;
  logic [7:0] seg = 8'h00;
  logic [7:0] dig_b, seg_b;
  assign dig_b = ~dig;
  assign seg_b = ~seg;

  logic [7:0] hex_a [8];
  logic [7:0] hex_b [8];
  logic [7:0] valid_a, valid_b, update_a, update_b;
  logic       mh_a, mh_b;

  seg7_mux_capture #(
    .W_DIGIT(8), .W_SEG(8), .SETTLE(SET_A), .TIMEOUT(TMO_A),
    .DIGIT_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst(rst), .hgfedcba(seg), .digit(dig),
    .hex(hex_a), .valid(valid_a), .update(update_a), .multi_hot(mh_a)
  );

  seg7_mux_capture #(
    .W_DIGIT(8), .W_SEG(8), .SETTLE(SET_B), .TIMEOUT(TMO_B),
    .DIGIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .hgfedcba(seg_b), .digit(dig_b),
    .hex(hex_b), .valid(valid_b), .update(update_b), .multi_hot(mh_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int upd_cnt_a = 0;
  int mh_cnt_a  = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int         settle_p [2] = '{SET_A, SET_B};
  int         tmo_p    [2] = '{TMO_A, TMO_B};
  logic [7:0] m_hex [2][8];
  int         m_age [2][8];
  logic [15:0] m_last [2];
  int         m_run  [2];
  int         q_a[$];
  int         q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_a();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = hex_a[i];
    return p;
  endfunction

  function automatic logic [63:0] pack_b();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = hex_b[i];
    return p;
  endfunction

  function automatic logic [63:0] pack_m(input int k);
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = m_hex[k][i];
    return p;
  endfunction

  function automatic logic [7:0] valid_m(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (m_age[k][i] < tmo_p[k]);
    return v;
  endfunction

  task automatic push(input int k, input int code);
    if (k == 0) q_a.push_back(cyc * 16 + code);
    else        q_b.push_back(cyc * 16 + code);
  endtask

  // One clock edge of the model: a pattern seen on settle+1 consecutive
  // edges is captured once; one-hot writes a digit, multi-hot is flagged.
  task automatic model_edge(input int k);
    logic [15:0] pat;
    int ones, idx;
    pat = {dig, seg};
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_hex[k][i] = 8'h00;
        m_age[k][i] = tmo_p[k];
      end
      m_last[k] = 16'h0000;
      m_run[k]  = 1;
    end else begin
      if (pat == m_last[k]) m_run[k] = (m_run[k] < 1000) ? m_run[k] + 1 : 1000;
      else begin
        m_last[k] = pat;
        m_run[k]  = 1;
      end
      for (int i = 0; i < 8; i++)
        if (m_age[k][i] < tmo_p[k]) m_age[k][i]++;
      if (m_run[k] == settle_p[k] + 1) begin
        ones = $countones(dig);
        idx  = 0;
        for (int i = 0; i < 8; i++) if (dig[i]) idx = i;
        if (ones > 1) push(k, 8);
        else if (ones == 1) begin
          if (m_hex[k][idx] != seg) push(k, idx);
          m_hex[k][idx] = seg;
          m_age[k][idx] = 0;
        end
      end
      if (DECAY)
        for (int i = 0; i < 8; i++)
          if (m_age[k][i] >= tmo_p[k]) m_hex[k][i] = 8'h00;
    end
  endtask

  // Model advances on every active edge.
  always @(posedge clk) begin
    cyc++;
    model_edge(0);
    model_edge(1);
  end

  // Monitor: pops expected pulses for this cycle and compares state.
  always @(negedge clk) begin
    logic [8:0] obs, expm;
    int v;
    for (int k = 0; k < 2; k++) begin
      obs  = (k == 0) ? {mh_a, update_a} : {mh_b, update_b};
      expm = '0;
      if (k == 0) begin
        while (q_a.size() > 0 && q_a[0] / 16 <= cyc) begin
          v = q_a.pop_front();
          expm[v % 16] = 1'b1;
        end
      end else begin
        while (q_b.size() > 0 && q_b[0] / 16 <= cyc) begin
          v = q_b.pop_front();
          expm[v % 16] = 1'b1;
        end
      end
      if (obs != '0 || expm != '0)
        check((k == 0) ? "pulses_a" : "pulses_b", 64'(obs), 64'(expm));
      check((k == 0) ? "hex_a" : "hex_b", (k == 0) ? pack_a() : pack_b(), pack_m(k));
      check((k == 0) ? "valid_a" : "valid_b", 64'((k == 0) ? valid_a : valid_b),
            64'(valid_m(k)));
    end
    upd_cnt_a += $countones(update_a);
    mh_cnt_a  += int'(mh_a);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int base, a, b, r;
    logic [63:0] snap;

    tick(3);
    check("rst_hex_a", pack_a(), 64'h0);
    check("rst_valid_a", 64'(valid_a), 64'h0);
    check("rst_pulses_a", 64'({mh_a, update_a}), 64'h0);
    rst = 1'b0;

    // Held digit 2 captures on the 5th edge.
    dig = 8'h04; seg = 8'h3F;
    tick(4);
    check("t1_before_settle", 64'(hex_a[2]), 64'h0);
    tick(1);
    check("t1_hex2", 64'(hex_a[2]), 64'h3F);
    check("t1_update", 64'(update_a), 64'h04);
    check("t1_valid2", 64'(valid_a[2]), 64'h1);
    check("t1_others", pack_a() & ~(64'hFF << 16), 64'h0);
    tick(5);

    // Too-short scan is ignored.
    base = upd_cnt_a;
    dig = 8'h01; seg = 8'h06;
    tick(3);
    dig = 8'h00; seg = 8'h00;
    tick(6);
    check("t2_hex0", 64'(hex_a[0]), 64'h0);
    check("t2_valid0", 64'(valid_a[0]), 64'h0);
    check("t2_no_update", 64'(upd_cnt_a - base), 64'h0);

    // Multi-hot select flagged once, no capture.
    base = mh_cnt_a;
    snap = pack_a();
    dig = 8'h03; seg = 8'hFF;
    tick(10);
    dig = 8'h00; seg = 8'h00;
    tick(2);
    check("t3_multi_hot_once", 64'(mh_cnt_a - base), 64'h1);
    check("t3_hex_unchanged", pack_a(), snap);

    // Active-low instance sees raw FE / C0.
    dig = 8'h01; seg = 8'h3F;
    tick(6);
    check("t4_hex_b0", 64'(hex_b[0]), 64'h3F);
    check("t4_hex_a0", 64'(hex_a[0]), 64'h3F);
    dig = 8'h00; seg = 8'h00;
    tick(2);

    // Timeout on instance b (TIMEOUT=16, SETTLE=2).
    dig = 8'h20; seg = 8'h5B;
    tick(3);
    check("t5_cap_valid", 64'(valid_b[5]), 64'h1);
    check("t5_cap_hex", 64'(hex_b[5]), 64'h5B);
    dig = 8'h00; seg = 8'h00;
    tick(15);
    check("t5_valid_at15", 64'(valid_b[5]), 64'h1);
    tick(1);
    check("t5_valid_at16", 64'(valid_b[5]), 64'h0);
    check("t5_hex_at16", 64'(hex_b[5]), DECAY ? 64'h0 : 64'h5B);

    // Continuous scan, two passes of identical values.
    for (int pass = 0; pass < 2; pass++) begin
      base = upd_cnt_a;
      for (int d = 0; d < 8; d++) begin
        dig = 8'(1 << d);
        seg = 8'(d);
        tick(6);
      end
      check(pass == 0 ? "t6_updates_pass0" : "t6_updates_pass1",
            64'(upd_cnt_a - base), pass == 0 ? 64'd8 : 64'd0);
    end
    check("t6_all_valid", 64'(valid_a), 64'hFF);

    // Randomised scan traffic with occasional resets.
    repeat (300) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) dig = 8'h00;
      else if (r < 4) begin
        a = int'($urandom_range(0, 7));
        b = (a + int'($urandom_range(1, 7))) % 8;
        dig = 8'(1 << a) | 8'(1 << b);
      end else dig = 8'(1 << $urandom_range(0, 7));
      seg = 8'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      tick(int'($urandom_range(1, 7)));
      rst = 1'b0;
    end
    dig = 8'h00; seg = 8'h00;
    tick(4);
    check("drain_a", 64'(q_a.size()), 64'h0);
    check("drain_b", 64'(q_b.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
